// File: rtl/mpeg2enc_pkg.sv
// Shared definitions for the MPEG-2 encoder host master: register map,
// status bit positions and the sequencing state encoding.
package mpeg2enc_pkg;

   localparam logic [7:0] STATUS_ADDR  = 8'h00;
   localparam logic [7:0] BUF1_ADDR    = 8'h04;
   localparam logic [7:0] BUF2_ADDR    = 8'h08;
   localparam logic [7:0] RELEASE_ADDR = 8'h0C;

   localparam int STAT_READY = 0;
   localparam int STAT_BUF1  = 1;
   localparam int STAT_BUF2  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL_READY,
      ST_WRITE_START,
      ST_POLL_BUF,
      ST_READ,
      ST_RELEASE,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/mpeg2enc_host_master_if.sv
// Register-bus and output-stream signals between the host master and the
// encoder slave / stream sink.
interface mpeg2enc_host_master_if;

   logic [7:0]  bus_addr;
   logic        bus_rd_en;
   logic        bus_wr_en;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;

   modport master (
      output bus_addr, bus_rd_en, bus_wr_en, bus_wdata, m_data, m_valid,
      input  bus_rdata, m_ready
   );

   modport slave (
      input  bus_addr, bus_rd_en, bus_wr_en, bus_wdata, m_data, m_valid,
      output bus_rdata, m_ready
   );

endinterface

// File: rtl/mpeg2enc_out_slot.sv
// Single-entry valid/ready holding register; free tells the sequencer a new
// word may be captured on the coming edge without overwriting an unsent one.
module mpeg2enc_out_slot (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] load_data,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] data,
   output logic        free
);

   assign free = !valid || ready;

   // A load on the same edge as an accept replaces the word with no bubble.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mpeg2enc_host_master.sv
// Bus initiator that starts the MPEG-2 encoder, drains its ping-pong output
// buffers word by word, releases them, and streams the words to a sink.
module mpeg2enc_host_master
   import mpeg2enc_pkg::*;
#(
   parameter int WORDS_PER_BUF  = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_bufs,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   mpeg2enc_host_master_if.master bus
);

   localparam int WORD_W = $clog2(WORDS_PER_BUF + 1);
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_BUF - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   state_t             state;
   logic               rd_q;
   logic               wr_q;
   logic [7:0]         addr_q;
   logic [31:0]        wdata_q;
   logic               cur;
   logic [CNT_W-1:0]   num_bufs_q;
   logic [CNT_W-1:0]   buf_cnt;
   logic [WORD_W-1:0]  word_cnt;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               busy_q;
   logic               done_q;
   logic               error_q;

   logic               slot_free;
   logic               slot_valid;
   logic [31:0]        slot_data;
   logic               rd_fire;
   logic               cur_full;
   logic               poll_fail;
   logic               abort_now;

   // Buffer reads are the only strobe that waits on the sink, so the
   // registered read request is gated by slot availability in READ.
   assign rd_fire   = rd_q && ((state != ST_READ) || slot_free);
   assign cur_full  = cur ? bus.bus_rdata[STAT_BUF2] : bus.bus_rdata[STAT_BUF1];
   assign poll_fail = ((state == ST_POLL_READY) && !bus.bus_rdata[STAT_READY]) ||
                      ((state == ST_POLL_BUF)   && !cur_full);
   assign abort_now = poll_fail && (wait_cnt == WAIT_LAST);

   assign bus.bus_rd_en = rd_fire;
   assign bus.bus_wr_en = wr_q;
   assign bus.bus_addr  = (rd_fire || wr_q) ? addr_q : 8'h00;
   assign bus.bus_wdata = wr_q ? wdata_q : 32'h0;
   assign bus.m_valid   = slot_valid;
   assign bus.m_data    = slot_data;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;

   mpeg2enc_out_slot u_slot (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      ((state == ST_READ) && rd_fire),
      .flush     (abort_now),
      .load_data (bus.bus_rdata),
      .ready     (bus.m_ready),
      .valid     (slot_valid),
      .data      (slot_data),
      .free      (slot_free)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cur        <= 1'b0;
         num_bufs_q <= '0;
         buf_cnt    <= '0;
         word_cnt   <= '0;
         wait_cnt   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (abort_now) begin
            rd_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state   <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (num_bufs != '0) begin
                        num_bufs_q <= num_bufs;
                        busy_q     <= 1'b1;
                        buf_cnt    <= '0;
                        word_cnt   <= '0;
                        wait_cnt   <= '0;
                        cur        <= 1'b0;
                        rd_q       <= 1'b1;
                        addr_q     <= STATUS_ADDR;
                        state      <= ST_POLL_READY;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               ST_POLL_READY: begin
                  if (!poll_fail) begin
                     rd_q    <= 1'b0;
                     wr_q    <= 1'b1;
                     addr_q  <= STATUS_ADDR;
                     wdata_q <= 32'h1;
                     state   <= ST_WRITE_START;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
               ST_WRITE_START: begin
                  wr_q     <= 1'b0;
                  rd_q     <= 1'b1;
                  addr_q   <= STATUS_ADDR;
                  cur      <= 1'b0;
                  wait_cnt <= '0;
                  state    <= ST_POLL_BUF;
               end
               ST_POLL_BUF: begin
                  if (!poll_fail) begin
                     addr_q   <= cur ? BUF2_ADDR : BUF1_ADDR;
                     word_cnt <= '0;
                     state    <= ST_READ;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
               ST_READ: begin
                  if (rd_fire) begin
                     if (word_cnt == WORD_LAST) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b1;
                        addr_q  <= RELEASE_ADDR;
                        wdata_q <= cur ? 32'h2 : 32'h1;
                        state   <= ST_RELEASE;
                     end else begin
                        word_cnt <= word_cnt + WORD_W'(1);
                     end
                  end
               end
               ST_RELEASE: begin
                  wr_q    <= 1'b0;
                  cur     <= ~cur;
                  buf_cnt <= buf_cnt + CNT_W'(1);
                  if ((buf_cnt + CNT_W'(1)) == num_bufs_q) begin
                     addr_q <= '0;
                     state  <= ST_FINISH;
                  end else begin
                     rd_q     <= 1'b1;
                     addr_q   <= STATUS_ADDR;
                     wait_cnt <= '0;
                     state    <= ST_POLL_BUF;
                  end
               end
               ST_FINISH: begin
                  // Completion waits for the sink to take the last word.
                  if (!slot_valid) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/mpeg2enc_host_master.md
Name: mpeg2enc_host_master

Overview:
- Bus initiator for the MPEG-2 encoder register slave. Drives the slave's addr/rd_en/wr_en/data interface from the master side.
- Sequence: wait for encoder ready, write start, drain the two ping-pong output buffers (buf1, buf2) word by word, release each buffer, and stream the words to a local valid/ready sink.
- Sits between the encoder peripheral and the frame-store/DMA logic, so no processor is needed per buffer.

Parameters:
- WORDS_PER_BUF, 16, 32-bit words read from one buffer before it is released.
- TIMEOUT_CYCLES, 1024, maximum poll cycles in any wait state before error.
- CNT_W, 16, width of num_bufs and the buffer counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; ignored while busy
- num_bufs  in  CNT_W  buffers to drain this job; latched on accepted start; 0 means done immediately
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at normal job completion
- error  out  1  one-cycle pulse on timeout abort
- bus_addr  out  8  slave register address
- bus_rd_en  out  1  slave read strobe
- bus_wr_en  out  1  slave write strobe
- bus_wdata  out  32  data to slave dataIn
- bus_rdata  in  32  slave dataOut; combinational, valid in the same cycle as bus_rd_en
- m_data  out  32  stream word
- m_valid  out  1  stream word valid
- m_ready  in  1  sink accepts word

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-low, sampled on the rising edge of clock.
  - Reset values: all outputs 0, state IDLE, counters 0.
  - Reset mid-job aborts it; strobes drop on the same edge; no release write is issued.
- Register map (shared package):
  - STATUS_ADDR 8'h00: read bit0 = ready, bit1 = buf1 full, bit2 = buf2 full. Write bit0 = start.
  - BUF1_ADDR 8'h04 and BUF2_ADDR 8'h08: each read pops one word.
  - RELEASE_ADDR 8'h0C: write bit0 releases buf1, bit1 releases buf2.
- Bus rules:
  - At most one strobe per cycle; rd_en and wr_en are never high together.
  - Every access is exactly one cycle.
  - bus_addr and bus_wdata are meaningful only while a strobe is high; otherwise they hold 0.
  - Read data is captured at the edge ending the rd_en cycle.
- State machine (registered outputs; one bus access per cycle):
  - IDLE: on start with num_bufs≠0, latch num_bufs, set busy, clear counters, go POLL_READY. On start with num_bufs=0, pulse done only; busy stays 0.
  - POLL_READY: rd STATUS each cycle. If bit0=1, go WRITE_START.
  - WRITE_START: wr STATUS, wdata=32'h1, one cycle, then go POLL_BUF with cur=buf1.
  - POLL_BUF: rd STATUS each cycle. If the full bit of cur (bit1 for buf1, bit2 for buf2) is 1, go READ.
  - READ: issue rd on the cur buffer address only when the output slot is free (!m_valid || m_ready). Otherwise drive no strobe that cycle.
    - Captured word goes to m_data, m_valid=1 the next cycle.
    - After WORDS_PER_BUF reads, go RELEASE.
  - RELEASE: wr RELEASE_ADDR with wdata=1<<cur. Increment the buffer count and toggle cur.
    - If count==num_bufs, go FINISH; else go POLL_BUF.
  - FINISH: wait until m_valid=0 (last word accepted), then pulse done, clear busy, go IDLE.
- Stream:
  - m_valid clears on m_valid&&m_ready unless a new word is captured the same edge.
  - Simultaneous accept and capture keeps m_valid=1 with the new data; no bubble is required.
  - No word is dropped or duplicated.
- Timeout:
  - A wait counter runs in POLL_READY and POLL_BUF and resets on every state entry.
  - When it reaches TIMEOUT_CYCLES without success: pulse error, clear busy, flush m_valid, go IDLE. No release is written.
- Counter widths:
  - Word counter is $clog2(WORDS_PER_BUF+1) bits.
  - Buffer counter is CNT_W bits; the compare is exact equality, with no wrap within a job.

Decomposition:
- Package mpeg2enc_pkg holds:
  - Register address constants and status bit indices (STAT_READY=0, STAT_BUF1=1, STAT_BUF2=2).
  - The state enum.
- One sub-module, mpeg2enc_out_slot: single-entry valid/ready holding register providing a free flag to the FSM.

Test Plan:
- Basic drain: slave ready immediately, buf1 full after 3 cycles, buf2 full later; num_bufs=2, WORDS_PER_BUF=16 → 1 start write (addr 0, data 1), 32 reads alternating 16@0x04 then 16@0x08, release writes data 1 then 2, stream words in order, then a single done pulse.
- Backpressure: m_ready low for 5 cycles mid-buffer → no rd_en during the stall, word held stable, no loss or duplication, 16 words per buffer total.
- Timeout: status bit0 held 0, TIMEOUT_CYCLES=8 → exactly 8 status reads, error pulse, busy=0, no write ever issued.
- Start while busy and num_bufs=0: second start mid-job is ignored and the job completes normally; start with num_bufs=0 → done one cycle later with zero bus accesses.
- Reset mid-READ: reset_n low at word 7 of buf1 → next edge all strobes, m_valid and busy are 0; a later fresh start runs a full correct job.
- Odd count: num_bufs=3 → buffer order buf1, buf2, buf1; releases 1, 2, 1; 48 words; done once.
